fpu_flag_monitor: RTL
=====================

FPU_FLAG_MONITOR -- requirements
Module: fpu_flag_monitor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the operand width, sign bit at WIDTH-1.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of each saturating counter.
REQ-003 The block SHALL have parameter TS_W, default 32, meaning the width of the cycle timestamp.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning violation-record FIFO entries (power of two, >=2).
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port in_valid, input, 1 bit: qualifies the operation inputs this cycle.
REQ-008 Port fpu_op, input, 3 bits: operation code; divide equals package constant DIV_OP = 3.
REQ-009 Port opb, input, WIDTH bits: operand B.
REQ-010 Ports overflow, underflow, div_by_zero, input, 1 bit each: DUT exception flags.
REQ-011 Port rule_en, input, 3 bits: per-rule enable, bit i enables rule Ri.
REQ-012 Port clear, input, 1 bit: synchronous clear of all monitor state.
REQ-013 Ports rec_valid (output, 1), rec_ready (input, 1): valid/ready handshake for violation records.
REQ-014 Ports rec_rules (output, 3) and rec_time (output, TS_W): head record's rule mask and timestamp.
REQ-015 Port viol_sticky, output, 3 bits: sticky per-rule violation flags.
REQ-016 Port viol_cnt, output, 3*CNT_W bits: per-rule counters, rule i at bits [i*CNT_W +: CNT_W].
REQ-017 Port drop_cnt, output, CNT_W bits: saturating count of records lost to a full FIFO.
REQ-018 Port irq, output, 1 bit: registered OR of viol_sticky.

Function
REQ-019 Rule R0 SHALL fire when overflow and underflow are both 1.
REQ-020 Rule R1 SHALL fire when fpu_op==DIV_OP, opb[WIDTH-2:0]==0 (either sign) and div_by_zero==0.
REQ-021 Rule R2 SHALL fire when div_by_zero==1 and the R1 divide-by-zero condition is false.
REQ-022 Rule evaluation SHALL be qualified by in_valid and rule_en; inputs with in_valid=0 SHALL have no effect, including X-valued ones.
REQ-023 Inputs SHALL be registered once; sticky, counters, FIFO and drop_cnt SHALL reflect inputs presented at edge N after edge N+1; irq after edge N+2.
REQ-024 Each firing rule SHALL set its sticky bit and increment its counter by 1, saturating at 2^CNT_W-1.
REQ-025 A cycle with any firing rule SHALL push exactly one record: mask of all firing rules plus the timestamp of the sampling edge.
REQ-026 The timestamp SHALL be a free-running TS_W counter, incrementing every cycle and wrapping to 0.
REQ-027 A push with the FIFO full and no same-cycle pop SHALL drop the record and increment drop_cnt, saturating.
REQ-028 A push with the FIFO full and a same-cycle pop SHALL be accepted with no drop.
REQ-029 A pop SHALL occur on rec_valid && rec_ready; the record SHALL be held stable while rec_valid=1 and rec_ready=0.
REQ-030 A pop on an empty FIFO SHALL be ignored; pointers SHALL wrap modulo DEPTH.
REQ-031 clear SHALL zero sticky bits, counters and drop_cnt, and flush the FIFO; it SHALL take priority over same-cycle updates, and the timestamp SHALL keep running.

Reset
REQ-032 On rst_n=0, all state SHALL reset asynchronously to 0: timestamp, input register, sticky bits, counters, drop_cnt, FIFO pointers, rec_valid and irq.
REQ-033 Reset asserted mid-operation SHALL discard pending records; the first evaluation after release SHALL use inputs sampled after release.

Structure
REQ-034 Package fpu_mon_pkg SHALL hold DIV_OP, rule index enum (R_OVF_UNF, R_DBZ_MISS, R_DBZ_SPUR) and the record struct {rules, time}.
REQ-035 The FIFO SHALL be a sub-module fpu_mon_fifo, parametrised by DEPTH and record type, with full/empty outputs.

Verification
REQ-036 Test 1: in_valid=1, overflow=underflow=1, rule_en=7 -> viol_sticky=3'b001, viol_cnt[R0]=1, one record rules=001 two edges later, irq=1.
REQ-037 Test 2: fpu_op=3, opb=32'h8000_0000, div_by_zero=0 -> R1 fires; with div_by_zero=1 and opb=32'h3F80_0000 -> R2 fires; the record mask is 010, then 100.
REQ-038 Test 3: rec_ready=0, 6 consecutive violating cycles, DEPTH=4 -> 4 records retained in order, drop_cnt=2.
REQ-039 Test 4: full FIFO with push and pop in the same cycle -> drop_cnt unchanged, occupancy stays 4.
REQ-040 Test 5: CNT_W=4, 20 R0 violations -> viol_cnt[R0]=15; clear then asserted with a violation in the same cycle -> all counters 0 and FIFO empty.
REQ-041 Test 6: rst_n pulsed low while records are pending -> rec_valid=0 and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_mon_pkg.sv
// Shared definitions for the FPU exception-flag monitor: opcode, rule indices
// and the violation record layout.
package fpu_mon_pkg;

  localparam logic [2:0] DIV_OP    = 3'd3;
  localparam int         NUM_RULES = 3;
  localparam int         REC_TS_W  = 32;

  typedef enum logic [1:0] {
    R_OVF_UNF  = 2'd0,
    R_DBZ_MISS = 2'd1,
    R_DBZ_SPUR = 2'd2
  } rule_e;

  typedef logic [NUM_RULES-1:0] rule_mask_t;

  typedef struct packed {
    rule_mask_t            rules;
    logic [REC_TS_W-1:0]   ts;
  } rec_t;

endpackage

// File: rtl/fpu_mon_fifo.sv
// Small synchronous FIFO for violation records, with flush.
// A push is accepted when the FIFO is full only if a pop happens in the same cycle.
module fpu_mon_fifo
  import fpu_mon_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = rec_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic push_i,
  input  T     din_i,
  input  logic pop_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  T           mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // The extra pointer bit separates full from empty; wrap is modulo DEPTH.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers define which entries are live,
  // and the top masks the head record whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push && !clr_i) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/fpu_flag_monitor.sv
// Watches FPU exception flags for inconsistent combinations, keeps sticky flags,
// saturating counters and a FIFO of time-stamped violation records.
module fpu_flag_monitor
  import fpu_mon_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [2:0]             fpu_op,
  input  logic [WIDTH-1:0]       opb,
  input  logic                   overflow,
  input  logic                   underflow,
  input  logic                   div_by_zero,
  input  logic [2:0]             rule_en,
  input  logic                   clear,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [2:0]             rec_rules,
  output logic [TS_W-1:0]        rec_time,
  output logic [2:0]             viol_sticky,
  output logic [3*CNT_W-1:0]     viol_cnt,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   irq
);

  // Same layout as rec_t, but with the timestamp sized by TS_W.
  typedef struct packed {
    rule_mask_t        rules;
    logic [TS_W-1:0]   ts;
  } mon_rec_t;

  rule_mask_t                        hit_d, hit_q, sticky_q;
  logic [TS_W-1:0]                   ts_q, samp_ts_q;
  logic [NUM_RULES-1:0][CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]                  drop_q;
  logic                              irq_q;
  logic                              dbz_cond;
  logic                              push, pop, fifo_full, fifo_empty, drop;
  mon_rec_t                          push_rec, head_rec;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    // Shifting out the sign bit makes +0 and -0 both count as zero.
    dbz_cond = (fpu_op == DIV_OP) && ((opb << 1) == '0);
    hit_d    = '0;
    if (in_valid) begin
      hit_d[R_OVF_UNF]  = overflow & underflow;
      hit_d[R_DBZ_MISS] = dbz_cond & ~div_by_zero;
      hit_d[R_DBZ_SPUR] = div_by_zero & ~dbz_cond;
      hit_d             = hit_d & rule_en;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q      <= '0;
      hit_q     <= '0;
      samp_ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
      if (clear) begin
        hit_q     <= '0;
        samp_ts_q <= '0;
      end else begin
        hit_q     <= hit_d;
        samp_ts_q <= ts_q;
      end
    end
  end

  assign push     = (|hit_q) & ~clear;
  assign pop      = rec_ready & rec_valid;
  assign drop     = push & fifo_full & ~pop;
  assign push_rec = '{rules: hit_q, ts: samp_ts_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
      cnt_q    <= '0;
      drop_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= |sticky_q;
      if (clear) begin
        sticky_q <= '0;
        cnt_q    <= '0;
        drop_q   <= '0;
      end else begin
        sticky_q <= sticky_q | hit_q;
        for (int i = 0; i < NUM_RULES; i++) begin
          if (hit_q[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
        end
        if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
    end
  end

  fpu_mon_fifo #(
    .DEPTH (DEPTH),
    .T     (mon_rec_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clear),
    .push_i  (push),
    .din_i   (push_rec),
    .pop_i   (pop),
    .dout_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rec_valid   = ~fifo_empty;
  assign rec_rules   = rec_valid ? head_rec.rules : '0;
  assign rec_time    = rec_valid ? head_rec.ts : '0;
  assign viol_sticky = sticky_q;
  assign viol_cnt    = cnt_q;
  assign drop_cnt    = drop_q;
  assign irq         = irq_q;

endmodule
